// File: rtl/ee457_rf_pkg.sv
// Shared types and constants for the regfile write-port arbiter.
// Holds width defaults, arbiter state type and wait counter width.
package ee457_rf_pkg;

  localparam int RF_ADDR_SIZE = 5;
  localparam int RF_DATA_SIZE = 32;
  localparam int WAIT_CNT_W   = 4;

  typedef enum logic {
    PRI_A   = 1'b0,
    FORCE_B = 1'b1
  } arb_state_t;

endpackage

// File: rtl/ee457_rf_wr_stage.sv
// Registered regfile write stage with async clear.
// Ports: clk, rst_n, xfer/in_wa/in_wdata in; wen/wa/wdata out.
module ee457_rf_wr_stage
  import ee457_rf_pkg::*;
#(
  parameter int ADDR_SIZE = RF_ADDR_SIZE,
  parameter int DATA_SIZE = RF_DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 xfer,
  input  logic [ADDR_SIZE-1:0] in_wa,
  input  logic [DATA_SIZE-1:0] in_wdata,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] wa,
  output logic [DATA_SIZE-1:0] wdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen   <= 1'b0;
      wa    <= '0;
      wdata <= '0;
    end else begin
      // r0 writes complete the handshake but never pulse wen
      wen <= xfer && (in_wa != '0);
      if (xfer) begin
        wa    <= in_wa;
        wdata <= in_wdata;
      end
    end
  end

endmodule

// File: rtl/ee457_regfile_wr_arb.sv
// Two-requester regfile write-port arbiter, A priority, B starvation guard.
// Ports: a_*/b_* valid/ready requests in; registered wen/wa/wdata, b_forced out.
module ee457_regfile_wr_arb
  import ee457_rf_pkg::*;
#(
  parameter int ADDR_SIZE = RF_ADDR_SIZE,
  parameter int DATA_SIZE = RF_DATA_SIZE,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  input  logic [ADDR_SIZE-1:0] a_wa,
  input  logic [DATA_SIZE-1:0] a_wdata,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [ADDR_SIZE-1:0] b_wa,
  input  logic [DATA_SIZE-1:0] b_wdata,
  output logic                 b_ready,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] wa,
  output logic [DATA_SIZE-1:0] wdata,
  output logic                 b_forced
);

  localparam logic [WAIT_CNT_W-1:0] MAX_C =
    WAIT_CNT_W'(MAX_WAIT);
  localparam logic [WAIT_CNT_W-1:0] LAST_C =
    WAIT_CNT_W'(MAX_WAIT - 1);

  arb_state_t state, state_nxt;
  logic [WAIT_CNT_W-1:0] wait_cnt, wait_nxt;

  logic                 a_xfer, b_xfer, xfer;
  logic [ADDR_SIZE-1:0] win_wa;
  logic [DATA_SIZE-1:0] win_wdata;

  always_comb begin
    a_ready   = 1'b1;
    b_ready   = !a_valid;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    unique case (state)
      PRI_A: begin
        if (!b_valid || b_ready) begin
          wait_nxt = '0;
        end else begin
          // refused for the MAX_WAIT-th time: force next cycle
          if (wait_cnt == LAST_C)
            state_nxt = FORCE_B;
          if (wait_cnt != MAX_C)
            wait_nxt = wait_cnt + 1'b1;
        end
      end
      FORCE_B: begin
        a_ready   = 1'b0;
        b_ready   = 1'b1;
        // leaves on the B transfer, or on a dropped b_valid
        state_nxt = PRI_A;
        wait_nxt  = '0;
      end
      default: begin
        state_nxt = PRI_A;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= PRI_A;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign b_forced  = (state == FORCE_B);
  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign xfer      = a_xfer || b_xfer;
  assign win_wa    = a_xfer ? a_wa    : b_wa;
  assign win_wdata = a_xfer ? a_wdata : b_wdata;

  ee457_rf_wr_stage #(
    .ADDR_SIZE(ADDR_SIZE),
    .DATA_SIZE(DATA_SIZE)
  ) u_wr (
    .clk     (clk),
    .rst_n   (rst_n),
    .xfer    (xfer),
    .in_wa   (win_wa),
    .in_wdata(win_wdata),
    .wen     (wen),
    .wa      (wa),
    .wdata   (wdata)
  );

endmodule

// File: tb/tb_ee457_regfile_wr_arb.sv
// Directed self-checking bench for the regfile write-port arbiter.
// Inputs change 1ns after rising edges; outputs sampled away from edges.
module tb_ee457_regfile_wr_arb;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_wa;
  logic [31:0] a_wdata;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_wa;
  logic [31:0] b_wdata;
  logic        b_ready;
  logic        wen;
  logic [4:0]  wa;
  logic [31:0] wdata;
  logic        b_forced;

  int total = 0;
  int bad   = 0;

  ee457_regfile_wr_arb #(
    .ADDR_SIZE(5),
    .DATA_SIZE(32),
    .MAX_WAIT (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_wa    (a_wa),
    .a_wdata (a_wdata),
    .a_ready (a_ready),
    .b_valid (b_valid),
    .b_wa    (b_wa),
    .b_wdata (b_wdata),
    .b_ready (b_ready),
    .wen     (wen),
    .wa      (wa),
    .wdata   (wdata),
    .b_forced(b_forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_valid = 0; a_wa = 0; a_wdata = 0;
    b_valid = 0; b_wa = 0; b_wdata = 0;
  endtask

  task automatic test_reset;
    idle();
    rst_n = 0;
    #12;
    total++;
    if ({wen, wa, wdata} !== 38'd0) begin
      bad++;
      $display("FAIL reset_out got wen=%b wa=%0d wdata=%h want 0",
               wen, wa, wdata);
    end
    total++;
    if (b_forced !== 1'b0) begin
      bad++;
      $display("FAIL reset_forced got %b want 0", b_forced);
    end
    total++;
    if ({a_ready, b_ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready got %b want 11", {a_ready, b_ready});
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_a_alone;
    a_valid = 1; a_wa = 5; a_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL a_ready got %b want 1", a_ready);
    end
    total++;
    if (b_ready !== 1'b0) begin
      bad++;
      $display("FAIL a_blocks_b got %b want 0", b_ready);
    end
    tick();
    idle();
    total++;
    if ({wen, wa, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL a_write got wen=%b wa=%0d wdata=%h want 1/5/deadbeef",
               wen, wa, wdata);
    end
    tick();
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL a_wen_drop got %b want 0", wen);
    end
    total++;
    if (wa !== 5'd5) begin
      bad++;
      $display("FAIL a_wa_hold got %0d want 5", wa);
    end
  endtask

  task automatic test_b_alone;
    b_valid = 1; b_wa = 7; b_wdata = 32'h12345678;
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++;
      $display("FAIL b_ready got %b want 1", b_ready);
    end
    tick();
    idle();
    total++;
    if ({wen, wa, wdata} !== {1'b1, 5'd7, 32'h12345678}) begin
      bad++;
      $display("FAIL b_write got wen=%b wa=%0d wdata=%h want 1/7/12345678",
               wen, wa, wdata);
    end
    tick();
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL b_wen_drop got %b want 0", wen);
    end
  endtask

  task automatic test_starvation;
    int g0, g1;
    logic f;
    g0 = -1; g1 = -1;
    a_valid = 1; a_wa = 1; a_wdata = 32'hAAAA0001;
    b_valid = 1; b_wa = 2; b_wdata = 32'hBBBB0002;
    for (int c = 0; c < 10; c++) begin
      f = ((c % 5) == 4);
      #1;
      total++;
      if ({b_forced, a_ready, b_ready} !== {f, !f, f}) begin
        bad++;
        $display("FAIL starve_ctl c=%0d got %b want %b", c,
                 {b_forced, a_ready, b_ready}, {f, !f, f});
      end
      if (b_ready && b_valid) begin
        if (g0 < 0) g0 = c;
        else if (g1 < 0) g1 = c;
      end
      tick();
      total++;
      if ({wen, wa} !== {1'b1, f ? 5'd2 : 5'd1}) begin
        bad++;
        $display("FAIL starve_wr c=%0d got wen=%b wa=%0d want 1/%0d", c,
                 wen, wa, f ? 2 : 1);
      end
    end
    total++;
    if (g1 - g0 !== 5 || g0 !== 4) begin
      bad++;
      $display("FAIL starve_period got g0=%0d g1=%0d want 4/9", g0, g1);
    end
    idle();
    tick();
  endtask

  task automatic test_r0;
    a_valid = 1; a_wa = 0; a_wdata = 32'hFFFFFFFF;
    #1;
    total++;
    if (a_ready !== 1'b1) begin
      bad++;
      $display("FAIL r0_a_ready got %b want 1", a_ready);
    end
    tick();
    a_valid = 0;
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL r0_a_wen got %b want 0", wen);
    end
    b_valid = 1; b_wa = 0; b_wdata = 32'h5555AAAA;
    #1;
    total++;
    if (b_ready !== 1'b1) begin
      bad++;
      $display("FAIL r0_b_ready got %b want 1", b_ready);
    end
    tick();
    idle();
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL r0_b_wen got %b want 0", wen);
    end
    tick();
  endtask

  task automatic test_async_reset;
    a_valid = 1; a_wa = 9; a_wdata = 32'hCAFE0001;
    tick();
    idle();
    total++;
    if (wen !== 1'b1) begin
      bad++;
      $display("FAIL ar_pre_wen got %b want 1", wen);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({wen, wa, wdata} !== 38'd0) begin
      bad++;
      $display("FAIL ar_clear got wen=%b wa=%0d wdata=%h want 0",
               wen, wa, wdata);
    end
    tick();
    rst_n = 1;
    tick();
    // reset while forced
    a_valid = 1; a_wa = 3; a_wdata = 32'h3;
    b_valid = 1; b_wa = 4; b_wdata = 32'h4;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (b_forced !== 1'b1) begin
      bad++;
      $display("FAIL ar_force_pre got %b want 1", b_forced);
    end
    #2;
    rst_n = 0;
    #1;
    total++;
    if ({b_forced, a_ready, b_ready} !== 3'b010) begin
      bad++;
      $display("FAIL ar_force_clr got %b want 010",
               {b_forced, a_ready, b_ready});
    end
    tick();
    rst_n = 1;
    // counter restarted: B refused 4 more cycles before forcing
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (b_forced !== 1'b0 || b_ready !== 1'b0) begin
        bad++;
        $display("FAIL ar_restart i=%0d got f=%b br=%b want 0/0",
                 i, b_forced, b_ready);
      end
      tick();
    end
    total++;
    if (b_forced !== 1'b1) begin
      bad++;
      $display("FAIL ar_reforce got %b want 1", b_forced);
    end
    tick();
    idle();
    tick();
  endtask

  task automatic test_drop_in_force;
    a_valid = 1; a_wa = 10; a_wdata = 32'hA;
    b_valid = 1; b_wa = 11; b_wdata = 32'hB;
    for (int i = 0; i < 4; i++) tick();
    idle();
    #1;
    total++;
    if (b_forced !== 1'b1) begin
      bad++;
      $display("FAIL drop_pre got %b want 1", b_forced);
    end
    tick();
    total++;
    if ({wen, b_forced} !== 2'b00) begin
      bad++;
      $display("FAIL drop_post got wen=%b f=%b want 0/0", wen, b_forced);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [4:0] exp_wa [4];
    logic [31:0] exp_wd [4];
    exp_wa[0] = 3; exp_wa[1] = 4; exp_wa[2] = 6; exp_wa[3] = 8;
    exp_wd[0] = 32'hA3; exp_wd[1] = 32'hA4;
    exp_wd[2] = 32'hB6; exp_wd[3] = 32'hB8;
    b_valid = 1; b_wa = 6; b_wdata = 32'hB6;
    for (int c = 0; c < 4; c++) begin
      a_valid = (c < 2);
      a_wa    = exp_wa[c];
      a_wdata = exp_wd[c];
      if (c == 3) begin
        b_wa = 8; b_wdata = 32'hB8;
      end
      tick();
      total++;
      if ({wen, wa, wdata} !== {1'b1, exp_wa[c], exp_wd[c]}) begin
        bad++;
        $display("FAIL b2b c=%0d got wen=%b wa=%0d wdata=%h want 1/%0d/%h",
                 c, wen, wa, wdata, exp_wa[c], exp_wd[c]);
      end
    end
    idle();
    tick();
    total++;
    if (wen !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got %b want 0", wen);
    end
  endtask

  initial begin
    idle();
    rst_n = 1;
    #3;
    test_reset();
    test_a_alone();
    test_b_alone();
    test_starvation();
    test_r0();
    test_async_reset();
    test_drop_in_force();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ee457_regfile_wr_arb.md
# ee457_regfile_wr_arb

Write-port arbiter for the 2-read/1-write register file. It shares the single register-file write port between two requesters: requester A is the pipeline writeback stage and has priority; requester B is a multi-cycle unit such as mul/div or an outstanding load. A starvation guard bounds B's wait. The winning write is registered, so the arbiter sits directly in front of the regfile `wa`/`wdata`/`wen` inputs.

## Interface
Parameters:
- ADDR_SIZE, 5, register address width.
- DATA_SIZE, 32, write data width.
- MAX_WAIT, 4, consecutive cycles B may be refused before it is forced through; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- a_valid  in  1  A has a write pending.
- a_wa  in  ADDR_SIZE  A destination register.
- a_wdata  in  DATA_SIZE  A write data.
- a_ready  out  1  A write accepted this cycle when a_valid & a_ready.
- b_valid  in  1  B has a write pending.
- b_wa  in  ADDR_SIZE  B destination register.
- b_wdata  in  DATA_SIZE  B write data.
- b_ready  out  1  B write accepted this cycle when b_valid & b_ready.
- wen  out  1  registered write enable to the regfile.
- wa  out  ADDR_SIZE  registered write address to the regfile.
- wdata  out  DATA_SIZE  registered write data to the regfile.
- b_forced  out  1  high while the arbiter is in FORCE_B; for debug and performance counting.

## Operation
- FSM states: PRI_A (reset state) and FORCE_B.
- PRI_A:
  - a_ready = 1.
  - b_ready = !a_valid.
- FORCE_B:
  - a_ready = 0.
  - b_ready = 1.
- Ready outputs are combinational from state and a_valid only. They never depend on b_valid.
- Handshake rules:
  - A transfer occurs on the edge where valid & ready are both high.
  - A requester must hold valid, wa and wdata stable until accepted; violating this is a protocol error and behaviour is undefined.
  - At most one transfer occurs per cycle, by construction.
- Wait counter wait_cnt is 4 bits, reset 0:
  - In PRI_A, if b_valid & !b_ready: wait_cnt increments, saturating at MAX_WAIT.
  - On a B transfer, or if b_valid is low: wait_cnt clears to 0.
  - PRI_A goes to FORCE_B at the edge where wait_cnt == MAX_WAIT-1 and B is refused again. B is therefore refused exactly MAX_WAIT cycles, then granted.
  - FORCE_B goes to PRI_A on the B transfer, which always happens the first FORCE_B cycle given protocol compliance. wait_cnt clears on that transfer.
- Output register, on every edge:
  - wen <= (transfer occurred) & (winner's wa != 0).
  - wa/wdata <= winner's wa/wdata when a transfer occurs; otherwise they hold.
- Writes to r0 are accepted (the ready handshake completes) but produce no wen pulse.
- Arithmetic: no width conversion; wa/wdata are passed through bit-exact.

## Timing
- Reset values (async, while rst_n low): state PRI_A, wait_cnt 0, wen 0, wa 0, wdata 0, b_forced 0.
- a_ready = 1 immediately after reset; b_ready = !a_valid.
- Latency: a transfer at edge N yields wen/wa/wdata valid during cycle N..N+1. The regfile commits the write at edge N+1.
- Throughput: one write per cycle sustained. There are no bubbles between back-to-back transfers from the same or different requesters.
- Simultaneous A and B valid in PRI_A: A wins and B's wait_cnt advances.
- A continuously valid: B is granted exactly once every MAX_WAIT+1 cycles. During the FORCE_B cycle A sees a_ready = 0 and must hold.
- Reset asserted mid-operation:
  - Any in-flight registered write is dropped (wen forced 0 asynchronously).
  - Pending requests are not remembered; requesters re-present after reset.
- Requester dropping b_valid in FORCE_B (protocol error): FSM returns to PRI_A next edge, no write.

## Structure
- Shared package ee457_rf_pkg holds:
  - The ADDR_SIZE and DATA_SIZE defaults (5/32).
  - The arbiter state typedef {PRI_A, FORCE_B}.
  - The WAIT_CNT_W = 4 constant.
- Single module; no sub-module is required. The output write stage may optionally be factored as ee457_rf_wr_stage, which registers wen/wa/wdata with async clear.
- Regfile connection:
  - The regfile's wen/wa/wdata are driven only by this block.
  - Because the regfile has no internal forwarding, the hazard unit must treat the one-cycle output stage as an extra in-flight write.

## Test plan
- Reset then A alone: a_valid=1, a_wa=5, a_wdata=0xDEADBEEF for 1 cycle -> a_ready=1; next cycle wen=1, wa=5, wdata=0xDEADBEEF; following cycle wen=0.
- B alone: b_valid=1, b_wa=7, b_wdata=0x12345678, a_valid=0 -> b_ready=1 same cycle; wen=1, wa=7 one cycle later.
- Starvation with MAX_WAIT=4: a_valid held high with a_wa=1, b_valid high with b_wa=2 -> B refused 4 cycles, b_forced=1 and a_ready=0 in cycle 5, wen with wa=2 in cycle 6, then A resumes. Repeat and check the grant period is exactly 5 cycles.
- r0 filtering: a_wa=0, a_wdata=0xFFFFFFFF -> a_ready=1 handshake completes, wen stays 0.
- Async reset mid-stream: assert rst_n=0 between edges while wen=1 -> wen, wa and wdata go to 0 immediately; b_forced=0 and state PRI_A after release.
- Back-to-back alternation: A valid cycles 0–1, B valid cycles 0–3 -> wen high 4 consecutive cycles, in order wa A, A, B, B, with no gap.
